ebpc_stream_arbiter: RTL

//  Round-robin, burst-based merger of N_STREAMS valid/ready byte streams onto one output stream.

---
 rtl/ebpc_stream_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ebpc_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ebpc_stream_arbiter
//  Brief    : Round-robin burst merger of N valid/ready byte streams onto one
//             tagged output stream (id, end-of-frame, end-of-burst).
//  Revision : 1.0 - initial release
// ============================================================================
module ebpc_stream_arbiter #(
    parameter int N_STREAMS = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 8,
    parameter int ID_W      = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_STREAMS*DATA_W-1:0]   data_i,
    input  logic [N_STREAMS-1:0]          last_i,
    input  logic [N_STREAMS-1:0]          vld_i,
    output logic [N_STREAMS-1:0]          rdy_o,
    output logic [DATA_W-1:0]             data_o,
    output logic [ID_W-1:0]               id_o,
    output logic                          last_o,
    output logic                          eob_o,
    output logic                          vld_o,
    input  logic                          rdy_i
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant;
    logic [CNT_W-1:0]    cnt;

    logic [ID_W-1:0]     arb_idx;
    logic [ID_W-1:0]     cand;
    logic                arb_found;
    int                  arb_pos;

    logic [DATA_W-1:0]   g_data;
    logic                g_last;
    logic                out_free;
    logic                accept;
    logic                burst_end;

    // Cyclic search for the first valid stream at or after the pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        arb_pos   = 0;
        for (int i = 0; i < N_STREAMS; i++) begin
            arb_pos = (int'(ptr) + i) % N_STREAMS;
            cand    = ID_W'(arb_pos);
            if (!arb_found && vld_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        g_data = '0;
        g_last = 1'b0;
        for (int k = 0; k < N_STREAMS; k++) begin
            if (grant == ID_W'(k)) begin
                g_data = data_i[k*DATA_W +: DATA_W];
                g_last = last_i[k];
            end
        end
    end

    assign out_free  = ~vld_o | rdy_i;
    assign accept    = (state == S_BURST) && vld_i[grant] && out_free;
    assign burst_end = accept && (g_last || (cnt == CNT_W'(BURST_LEN - 1)));

    always_comb begin
        rdy_o = '0;
        if (state == S_BURST) begin
            rdy_o[grant] = out_free;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_found) state_nxt = S_BURST;
            S_BURST: if (burst_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr    <= '0;
            grant  <= '0;
            cnt    <= '0;
            data_o <= '0;
            id_o   <= '0;
            last_o <= 1'b0;
            eob_o  <= 1'b0;
            vld_o  <= 1'b0;
        end else begin
            if (state == S_IDLE && arb_found) begin
                grant <= arb_idx;
                cnt   <= '0;
            end
            if (accept) begin
                data_o <= g_data;
                id_o   <= grant;
                last_o <= g_last;
                eob_o  <= burst_end;
                vld_o  <= 1'b1;
                cnt    <= burst_end ? '0 : cnt + CNT_W'(1);
            end else if (rdy_i) begin
                vld_o  <= 1'b0;
            end
            if (burst_end) begin
                ptr <= (grant == ID_W'(N_STREAMS - 1)) ? '0 : grant + ID_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
